// File: rtl/axi_int_sequencer.sv
// axi_int_sequencer: AXI4-Lite master that runs the whole interrupt handshake
// against one axi_int slave from a single start pulse. It arms the interrupt,
// writes a data word, checks the readback, waits for irq, reads STATUS and DATA,
// acknowledges, waits for irq to drop and resets the slave's CTRL register.
module axi_int_sequencer #(
    parameter int C_M00_AXI_ADDR_WIDTH = 4,
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int IRQ_TIMEOUT          = 1024
) (
    input  logic                              m00_axi_aclk,
    input  logic                              m00_axi_aresetn,
    input  logic                              start,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]   tx_data,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic [2:0]                        err_code,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   rd_data,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   rd_status,
    input  logic                              irq,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                        m00_axi_awprot,
    output logic                              m00_axi_awvalid,
    input  logic                              m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                              m00_axi_wvalid,
    input  logic                              m00_axi_wready,
    input  logic [1:0]                        m00_axi_bresp,
    input  logic                              m00_axi_bvalid,
    output logic                              m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                        m00_axi_arprot,
    output logic                              m00_axi_arvalid,
    input  logic                              m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                        m00_axi_rresp,
    input  logic                              m00_axi_rvalid,
    output logic                              m00_axi_rready
);

    localparam int AW    = C_M00_AXI_ADDR_WIDTH;
    localparam int DW    = C_M00_AXI_DATA_WIDTH;
    localparam int CNT_W = $clog2(IRQ_TIMEOUT + 1);

    localparam logic [AW-1:0]    A_DATA = AW'(0);
    localparam logic [AW-1:0]    A_CTRL = AW'(4);
    localparam logic [AW-1:0]    A_STAT = AW'(8);
    localparam logic [AW-1:0]    A_IEN  = AW'(12);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(IRQ_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_IEN, S_WR_DATA, S_RD_CHK, S_WAIT_IRQ, S_RD_STAT,
        S_RD_DATA, S_WR_CLR, S_WAIT_NIRQ, S_WR_RST, S_DONE, S_ERR
    } state_t;

    state_t            state, next_st;
    logic              txn_act;     // a bus transaction has been issued in this state
    logic              aw_done, w_done;
    logic [DW-1:0]     tx_lat;
    logic [CNT_W-1:0]  irq_cnt;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [DW-1:0]     wr_val;
    logic              aw_ok, w_ok;

    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;
    assign m00_axi_wstrb  = '1;

    // Address channel / data channel accepted, either earlier or at this edge
    assign aw_ok = aw_done || (m00_axi_awvalid && m00_axi_awready);
    assign w_ok  = w_done  || (m00_axi_wvalid  && m00_axi_wready);

    // Per-state register target, write value and successor state
    always_comb begin
        next_st = S_IDLE;
        wr_addr = '0;
        wr_val  = '0;
        rd_addr = '0;
        case (state)
            S_WR_IEN:  begin next_st = S_WR_DATA;   wr_addr = A_IEN;  wr_val = DW'(1); end
            S_WR_DATA: begin next_st = S_RD_CHK;    wr_addr = A_DATA; wr_val = tx_lat; end
            S_RD_CHK:  begin next_st = S_WAIT_IRQ;  rd_addr = A_DATA; end
            S_RD_STAT: begin next_st = S_RD_DATA;   rd_addr = A_STAT; end
            S_RD_DATA: begin next_st = S_WR_CLR;    rd_addr = A_DATA; end
            S_WR_CLR:  begin next_st = S_WAIT_NIRQ; wr_addr = A_CTRL; wr_val = DW'(1); end
            S_WR_RST:  begin next_st = S_DONE;      wr_addr = A_CTRL; wr_val = DW'(2); end
            default:   ;
        endcase
    end

    // Sequencer FSM with registered bus and status outputs
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state           <= S_IDLE;
            txn_act         <= 1'b0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            m00_axi_awaddr  <= '0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wdata   <= '0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_araddr  <= '0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
            tx_lat          <= '0;
            irq_cnt         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            err_code        <= '0;
            rd_data         <= '0;
            rd_status       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tx_lat   <= tx_data;
                        busy     <= 1'b1;
                        err_code <= '0;
                        txn_act  <= 1'b0;
                        state    <= S_WR_IEN;
                    end
                end

                S_WR_IEN, S_WR_DATA, S_WR_CLR, S_WR_RST: begin
                    if (!txn_act) begin
                        // AW and W launch together; address/data held until accepted
                        txn_act         <= 1'b1;
                        aw_done         <= 1'b0;
                        w_done          <= 1'b0;
                        m00_axi_awaddr  <= wr_addr;
                        m00_axi_wdata   <= wr_val;
                        m00_axi_awvalid <= 1'b1;
                        m00_axi_wvalid  <= 1'b1;
                    end else begin
                        if (m00_axi_awvalid && m00_axi_awready) begin
                            m00_axi_awvalid <= 1'b0;
                            aw_done         <= 1'b1;
                        end
                        if (m00_axi_wvalid && m00_axi_wready) begin
                            m00_axi_wvalid <= 1'b0;
                            w_done         <= 1'b1;
                        end
                        if (!m00_axi_bready && aw_ok && w_ok)
                            m00_axi_bready <= 1'b1;
                        if (m00_axi_bvalid && m00_axi_bready) begin
                            m00_axi_bready <= 1'b0;
                            txn_act        <= 1'b0;
                            if (m00_axi_bresp != 2'b00) begin
                                state    <= S_ERR;
                                err      <= 1'b1;
                                busy     <= 1'b0;
                                err_code <= 3'd1;
                            end else begin
                                state <= next_st;
                                if (state == S_WR_CLR)
                                    irq_cnt <= '0;
                                if (state == S_WR_RST) begin
                                    done <= 1'b1;
                                    busy <= 1'b0;
                                end
                            end
                        end
                    end
                end

                S_RD_CHK, S_RD_STAT, S_RD_DATA: begin
                    if (!txn_act) begin
                        txn_act         <= 1'b1;
                        m00_axi_araddr  <= rd_addr;
                        m00_axi_arvalid <= 1'b1;
                    end else begin
                        if (m00_axi_arvalid && m00_axi_arready) begin
                            m00_axi_arvalid <= 1'b0;
                            m00_axi_rready  <= 1'b1;
                        end
                        if (m00_axi_rvalid && m00_axi_rready) begin
                            m00_axi_rready <= 1'b0;
                            txn_act        <= 1'b0;
                            if (state == S_RD_STAT)
                                rd_status <= m00_axi_rdata;
                            if (state == S_RD_DATA)
                                rd_data <= m00_axi_rdata;
                            if (m00_axi_rresp != 2'b00) begin
                                state <= S_ERR; err <= 1'b1; busy <= 1'b0; err_code <= 3'd1;
                            end else if (state == S_RD_STAT && !m00_axi_rdata[0]) begin
                                state <= S_ERR; err <= 1'b1; busy <= 1'b0; err_code <= 3'd4;
                            end else if (state != S_RD_STAT && m00_axi_rdata != tx_lat) begin
                                state <= S_ERR; err <= 1'b1; busy <= 1'b0; err_code <= 3'd2;
                            end else begin
                                state <= next_st;
                                if (state == S_RD_CHK)
                                    irq_cnt <= '0;
                            end
                        end
                    end
                end

                S_WAIT_IRQ: begin
                    if (irq)
                        state <= S_RD_STAT;
                    else if (irq_cnt == TO_M1) begin
                        state <= S_ERR; err <= 1'b1; busy <= 1'b0; err_code <= 3'd3;
                    end else
                        irq_cnt <= irq_cnt + 1'b1;
                end

                S_WAIT_NIRQ: begin
                    if (!irq)
                        state <= S_WR_RST;
                    else if (irq_cnt == TO_M1) begin
                        state <= S_ERR; err <= 1'b1; busy <= 1'b0; err_code <= 3'd5;
                    end else
                        irq_cnt <= irq_cnt + 1'b1;
                end

                // done/err pulse lives in these states; start here is ignored
                S_DONE, S_ERR: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
